regfile_wb_scheduler: RTL and testbench

REGFILE_WB_SCHEDULER -- requirements
Module: regfile_wb_scheduler

---
 rtl/regfile_wb_scheduler_pkg.sv | 14 +
 rtl/regfile_wb_scheduler_wb_arbiter.sv | 52 +++++
 rtl/regfile_wb_scheduler.sv | 105 ++++++++++
 tb/tb_regfile_wb_scheduler.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/regfile_wb_scheduler_pkg.sv
// Shared defaults and requester encoding for the register-file writeback scheduler.
// Optional feature macro: RR_ARB_EN (round-robin writeback arbitration).
package regfile_wb_scheduler_pkg;

    localparam int DATA_W_DEF = 64;
    localparam int ADDR_W_DEF = 5;
    localparam int NREGS_DEF  = 2 ** ADDR_W_DEF;

    typedef enum logic {
        REQ_ALU = 1'b0,
        REQ_MEM = 1'b1
    } req_id_t;

endpackage

// File: rtl/regfile_wb_scheduler_wb_arbiter.sv
// Single-port writeback arbiter between ALU and load results.
// RR_ARB_EN selects round-robin; otherwise MEM has fixed priority.
module wb_arbiter
    import regfile_wb_scheduler_pkg::*;
(
    input  logic clock,
    input  logic reset_n,
    input  logic alu_valid,
    input  logic mem_valid,
    output logic alu_grant,
    output logic mem_grant
);

`ifdef RR_ARB_EN
    req_id_t ptr_reg;
    req_id_t ptr_next;

    // The pointer names the requester that wins the next contention.
    always_comb begin
        alu_grant = 1'b0;
        mem_grant = 1'b0;
        ptr_next  = ptr_reg;
        if (alu_valid && mem_valid) begin
            if (ptr_reg == REQ_ALU) begin
                alu_grant = 1'b1;
                ptr_next  = REQ_MEM;
            end else begin
                mem_grant = 1'b1;
                ptr_next  = REQ_ALU;
            end
        end else begin
            alu_grant = alu_valid;
            mem_grant = mem_valid;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ptr_reg <= REQ_ALU;
        end else begin
            ptr_reg <= ptr_next;
        end
    end
`else
    logic unused_ports;

    assign mem_grant    = mem_valid;
    assign alu_grant    = alu_valid & ~mem_valid;
    assign unused_ports = clock ^ reset_n;
`endif

endmodule

// File: rtl/regfile_wb_scheduler.sv
// Register scoreboard plus single-write-port scheduler for ALU/load writebacks.
// Arbitration policy follows RR_ARB_EN (see wb_arbiter).
module regfile_wb_scheduler
    import regfile_wb_scheduler_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  issue_valid,
    input  logic [ADDR_W-1:0]     issue_rs,
    input  logic [ADDR_W-1:0]     issue_rt,
    input  logic [ADDR_W-1:0]     issue_rd,
    input  logic                  issue_wr,
    output logic                  issue_stall,
    input  logic                  alu_valid,
    input  logic [ADDR_W-1:0]     alu_rd,
    input  logic [DATA_W-1:0]     alu_data,
    output logic                  alu_ready,
    input  logic                  mem_valid,
    input  logic [ADDR_W-1:0]     mem_rd,
    input  logic [DATA_W-1:0]     mem_data,
    output logic                  mem_ready,
    output logic                  rf_regwrite,
    output logic [ADDR_W-1:0]     rf_writereg,
    output logic [DATA_W-1:0]     rf_writedata,
    output logic [2**ADDR_W-1:0]  busy
);

    localparam int NREGS = 2 ** ADDR_W;

    logic              alu_grant;
    logic              mem_grant;
    logic              wb_fire;
    logic [ADDR_W-1:0] wb_rd;
    logic [DATA_W-1:0] wb_data;
    logic              issue_set;

    // Register 0 has no scoreboard flop at all; busy[0] is tied low.
    logic [NREGS-1:1]  busy_reg;
    logic [NREGS-1:1]  set_vec;
    logic [NREGS-1:1]  clr_vec;

    logic              rf_regwrite_reg;
    logic [ADDR_W-1:0] rf_writereg_reg;
    logic [DATA_W-1:0] rf_writedata_reg;

    wb_arbiter u_arb (
        .clock     (clock),
        .reset_n   (reset_n),
        .alu_valid (alu_valid),
        .mem_valid (mem_valid),
        .alu_grant (alu_grant),
        .mem_grant (mem_grant)
    );

    assign alu_ready = reset_n & alu_grant;
    assign mem_ready = reset_n & mem_grant;
    assign wb_fire   = alu_ready | mem_ready;
    assign wb_rd     = mem_ready ? mem_rd   : alu_rd;
    assign wb_data   = mem_ready ? mem_data : alu_data;

    assign busy = {busy_reg, 1'b0};

    // Hazard check uses only the registered scoreboard: no same-cycle bypass.
    assign issue_stall = reset_n & issue_valid &
                         (busy[issue_rs] | busy[issue_rt] | (issue_wr & busy[issue_rd]));
    assign issue_set   = issue_valid & ~issue_stall & issue_wr;

    genvar gi;
    generate
        for (gi = 1; gi < NREGS; gi++) begin : g_dec
            assign set_vec[gi] = issue_set & (issue_rd == ADDR_W'(gi));
            assign clr_vec[gi] = wb_fire   & (wb_rd    == ADDR_W'(gi));
        end
    endgenerate

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            busy_reg <= '0;
        end else begin
            busy_reg <= (busy_reg & ~clr_vec) | set_vec;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rf_regwrite_reg  <= 1'b0;
            rf_writereg_reg  <= '0;
            rf_writedata_reg <= '0;
        end else begin
            rf_regwrite_reg <= wb_fire && (wb_rd != '0);
            if (wb_fire) begin
                rf_writereg_reg  <= wb_rd;
                rf_writedata_reg <= wb_data;
            end
        end
    end

    assign rf_regwrite  = rf_regwrite_reg;
    assign rf_writereg  = rf_writereg_reg;
    assign rf_writedata = rf_writedata_reg;

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Directed bench for regfile_wb_scheduler with a queue of expected register-file writes.
// Arbitration expectations follow RR_ARB_EN.
module tb_regfile_wb_scheduler;

    localparam int DATA_W = 64;
    localparam int ADDR_W = 5;
    localparam int NREGS  = 32;

    typedef struct packed {
        logic [ADDR_W-1:0] rd;
        logic [DATA_W-1:0] data;
    } wr_t;

    logic              clock = 1'b0;
    logic              reset_n;
    logic              issue_valid;
    logic [ADDR_W-1:0] issue_rs, issue_rt, issue_rd;
    logic              issue_wr;
    logic              issue_stall;
    logic              alu_valid;
    logic [ADDR_W-1:0] alu_rd;
    logic [DATA_W-1:0] alu_data;
    logic              alu_ready;
    logic              mem_valid;
    logic [ADDR_W-1:0] mem_rd;
    logic [DATA_W-1:0] mem_data;
    logic              mem_ready;
    logic              rf_regwrite;
    logic [ADDR_W-1:0] rf_writereg;
    logic [DATA_W-1:0] rf_writedata;
    logic [NREGS-1:0]  busy;

    int  checks = 0;
    int  errors = 0;
    wr_t exp_q[$];

    always #5 clock = ~clock;

    regfile_wb_scheduler #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .issue_valid  (issue_valid),
        .issue_rs     (issue_rs),
        .issue_rt     (issue_rt),
        .issue_rd     (issue_rd),
        .issue_wr     (issue_wr),
        .issue_stall  (issue_stall),
        .alu_valid    (alu_valid),
        .alu_rd       (alu_rd),
        .alu_data     (alu_data),
        .alu_ready    (alu_ready),
        .mem_valid    (mem_valid),
        .mem_rd       (mem_rd),
        .mem_data     (mem_data),
        .mem_ready    (mem_ready),
        .rf_regwrite  (rf_regwrite),
        .rf_writereg  (rf_writereg),
        .rf_writedata (rf_writedata),
        .busy         (busy)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        issue_valid = 1'b0; issue_rs = '0; issue_rt = '0; issue_rd = '0; issue_wr = 1'b0;
        alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
        mem_valid = 1'b0; mem_rd = '0; mem_data = '0;
    endtask

    task automatic issue(input logic [ADDR_W-1:0] rs, input logic [ADDR_W-1:0] rt,
                         input logic [ADDR_W-1:0] rd, input logic wr);
        issue_valid = 1'b1; issue_rs = rs; issue_rt = rt; issue_rd = rd; issue_wr = wr;
    endtask

    // Register-file write monitor: every strobe must match the oldest expected write.
    always @(negedge clock) begin
        if (reset_n === 1'b1 && rf_regwrite === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_write", {59'd0, rf_writereg}, 64'hFFFF);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                check("wb_reg",  {59'd0, rf_writereg}, {59'd0, e.rd});
                check("wb_data", rf_writedata, e.data);
                $display("write reg=%0d data=%0h", rf_writereg, rf_writedata);
            end
        end
    end

    initial begin
        idle_inputs();
        reset_n = 1'b0;
        @(negedge clock);
        // Requests during reset must not be acknowledged.
        alu_valid = 1'b1; mem_valid = 1'b1; issue(5'd0, 5'd0, 5'd1, 1'b1);
        #1;
        check("rst_alu_ready", {63'd0, alu_ready}, 64'd0);
        check("rst_mem_ready", {63'd0, mem_ready}, 64'd0);
        check("rst_stall",     {63'd0, issue_stall}, 64'd0);
        @(negedge clock);
        check("rst_busy",     {32'd0, busy}, 64'd0);
        check("rst_regwrite", {63'd0, rf_regwrite}, 64'd0);
        check("rst_writereg", {59'd0, rf_writereg}, 64'd0);
        check("rst_writedata", rf_writedata, 64'd0);
        idle_inputs();
        reset_n = 1'b1;
        @(negedge clock);

        // Busy set, RAW stall, ALU writeback clears it.
        issue(5'd0, 5'd0, 5'd5, 1'b1);
        #1 check("issue5_stall", {63'd0, issue_stall}, 64'd0);
        @(negedge clock);
        idle_inputs();
        check("busy5_set", {32'd0, busy}, 64'h20);
        issue(5'd5, 5'd0, 5'd6, 1'b0);
        alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 64'hAA;
        #1;
        check("raw_stall",     {63'd0, issue_stall}, 64'd1);
        check("alu_lone_grant", {63'd0, alu_ready}, 64'd1);
        check("alu_lone_mem",  {63'd0, mem_ready}, 64'd0);
        exp_q.push_back('{rd: 5'd5, data: 64'hAA});
        @(negedge clock);
        alu_valid = 1'b0;
        #1;
        check("busy5_clear",   {32'd0, busy}, 64'd0);
        check("stall_release", {63'd0, issue_stall}, 64'd0);
        idle_inputs();

        // Contention for four cycles.
        alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 64'h33;
        mem_valid = 1'b1; mem_rd = 5'd4; mem_data = 64'h44;
        for (int i = 0; i < 4; i++) begin
            logic exp_alu;
`ifdef RR_ARB_EN
            exp_alu = (i % 2 == 0);
`else
            exp_alu = 1'b0;
`endif
            #1;
            check("arb_alu_ready", {63'd0, alu_ready}, {63'd0, exp_alu});
            check("arb_mem_ready", {63'd0, mem_ready}, {63'd0, ~exp_alu});
            if (exp_alu) exp_q.push_back('{rd: 5'd3, data: 64'h33});
            else         exp_q.push_back('{rd: 5'd4, data: 64'h44});
            @(negedge clock);
        end
        idle_inputs();

        // Register 0 is never busy and never written.
        issue(5'd0, 5'd0, 5'd0, 1'b1);
        @(negedge clock);
        idle_inputs();
        check("r0_busy", {32'd0, busy}, 64'd0);
        mem_valid = 1'b1; mem_rd = 5'd0; mem_data = 64'h99;
        #1 check("r0_mem_ready", {63'd0, mem_ready}, 64'd1);
        @(negedge clock);
        idle_inputs();
        check("r0_no_write", {63'd0, rf_regwrite}, 64'd0);

        // Issue-set and writeback-clear of different registers in one cycle.
        issue(5'd0, 5'd0, 5'd2, 1'b1);
        @(negedge clock);
        idle_inputs();
        check("busy2_set", {32'd0, busy}, 64'h4);
        issue(5'd0, 5'd0, 5'd7, 1'b1);
        alu_valid = 1'b1; alu_rd = 5'd2; alu_data = 64'h22;
        #1 check("dual_alu_ready", {63'd0, alu_ready}, 64'd1);
        exp_q.push_back('{rd: 5'd2, data: 64'h22});
        @(negedge clock);
        idle_inputs();
        check("dual_busy", {32'd0, busy}, 64'h80);
        @(negedge clock);
        check("hold_regwrite", {63'd0, rf_regwrite}, 64'd0);
        check("hold_writereg", {59'd0, rf_writereg}, 64'd2);
        check("hold_writedata", rf_writedata, 64'h22);
        mem_valid = 1'b1; mem_rd = 5'd7; mem_data = 64'h77;
        exp_q.push_back('{rd: 5'd7, data: 64'h77});
        @(negedge clock);
        idle_inputs();
        check("busy7_clear", {32'd0, busy}, 64'd0);

        // Reset arriving between grant and the registering edge drops the write.
        issue(5'd0, 5'd0, 5'd9, 1'b1);
        @(negedge clock);
        idle_inputs();
        check("busy9_set", {32'd0, busy}, 64'h200);
        alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 64'h99;
        #1 check("r9_alu_ready", {63'd0, alu_ready}, 64'd1);
        #1 reset_n = 1'b0;
        #1;
        check("midrst_regwrite", {63'd0, rf_regwrite}, 64'd0);
        check("midrst_busy", {32'd0, busy}, 64'd0);
        idle_inputs();
        @(negedge clock);
        reset_n = 1'b1;
        repeat (3) @(negedge clock);
        check("post_rst_regwrite", {63'd0, rf_regwrite}, 64'd0);
        check("post_rst_writereg", {59'd0, rf_writereg}, 64'd0);

        check("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
